// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle RV32I core control path.
package core_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        IO,
        WB
    } seq_state_t;

    localparam logic [1:0] REG_WRITE_DATA_SRC_RAM = 2'b01;

    // Decoder controls captured in EXEC so the later states do not depend on live decoder inputs.
    typedef struct packed {
        logic reg_we;
        logic store;
        logic stdin;
        logic stdout;
    } seq_ctrl_t;

endpackage

// File: rtl/core_sequencer_if.sv
// Control and strobe bundle between the core sequencer and the rest of the datapath.
interface core_sequencer_if;

    logic        run;
    logic        dec_reg_we;
    logic        dec_ram_we;
    logic [1:0]  dec_wsrc;
    logic        dec_stdin_en;
    logic        dec_stdout_en;
    logic        stdin_valid;
    logic        stdout_ready;

    logic        imem_req;
    logic        ir_we;
    logic        reg_we;
    logic        ram_we;
    logic        pc_we;
    logic        stdin_pop;
    logic        stdout_push;
    logic        busy;
    logic [31:0] cycle_count;
    logic [31:0] instret_count;

    modport master (
        input  run, dec_reg_we, dec_ram_we, dec_wsrc, dec_stdin_en, dec_stdout_en,
               stdin_valid, stdout_ready,
        output imem_req, ir_we, reg_we, ram_we, pc_we, stdin_pop, stdout_push,
               busy, cycle_count, instret_count
    );

    modport slave (
        output run, dec_reg_we, dec_ram_we, dec_wsrc, dec_stdin_en, dec_stdout_en,
               stdin_valid, stdout_ready,
        input  imem_req, ir_we, reg_we, ram_we, pc_we, stdin_pop, stdout_push,
               busy, cycle_count, instret_count
    );

endinterface

// File: rtl/seq_wait_counter.sv
// Loadable down-counter; o_last flags the final cycle of a multi-cycle FETCH or MEM state.
module seq_wait_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_last
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == '0);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/IO/WB sequencer for the single-issue RV32I core.
// Optional performance counters are built when SEQ_PERF_COUNTER_EN is defined.
module core_sequencer
    import core_pkg::*;
#(
    parameter int IMEM_LATENCY = 1,
    parameter int DMEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    core_sequencer_if.master  bus
);

    localparam int MAX_LAT = (IMEM_LATENCY > DMEM_LATENCY) ? IMEM_LATENCY : DMEM_LATENCY;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] FETCH_LOAD = CNT_W'(IMEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] LOAD_LOAD  = CNT_W'(DMEM_LATENCY - 1);

    seq_state_t       r_state;
    seq_state_t       w_next;
    seq_ctrl_t        r_ctrl;
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_load_val;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_last;
    logic             w_is_mem;
    logic             w_is_io;
    logic             w_io_done;

    assign w_is_mem  = bus.dec_ram_we | (bus.dec_wsrc == REG_WRITE_DATA_SRC_RAM);
    assign w_is_io   = bus.dec_stdin_en | bus.dec_stdout_en;
    assign w_io_done = r_ctrl.stdin ? bus.stdin_valid : bus.stdout_ready;

    seq_wait_counter #(.WIDTH(CNT_W)) u_wait (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .o_count    (w_cnt),
        .o_last     (w_cnt_last)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next         = r_state;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = '0;
        case (r_state)
            IDLE:   if (bus.run) w_next = FETCH;
            FETCH:  if (w_cnt_last) w_next = DECODE;
            DECODE: w_next = EXEC;
            EXEC: begin
                if (w_is_mem)     w_next = MEM;
                else if (w_is_io) w_next = IO;
                else              w_next = WB;
            end
            MEM:    if (w_cnt_last) w_next = WB;
            IO:     if (w_io_done) w_next = WB;
            WB:     w_next = bus.run ? FETCH : IDLE;
            default: w_next = IDLE;
        endcase

        // The counter is armed one cycle ahead so it already holds the state length on entry.
        if (w_next == FETCH && r_state != FETCH) begin
            w_cnt_load     = 1'b1;
            w_cnt_load_val = FETCH_LOAD;
        end else if (w_next == MEM && r_state != MEM) begin
            w_cnt_load     = 1'b1;
            w_cnt_load_val = bus.dec_ram_we ? '0 : LOAD_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == EXEC) begin
                r_ctrl <= '{
                    reg_we: bus.dec_reg_we & ~bus.dec_ram_we & ~bus.dec_stdout_en,
                    store:  bus.dec_ram_we,
                    stdin:  bus.dec_stdin_en,
                    stdout: bus.dec_stdout_en & ~bus.dec_stdin_en
                };
            end
        end
    end

    // Strobes decode flops only; the IO handshakes are the deliberate combinational exception.
    assign bus.imem_req    = (r_state == FETCH) && (w_cnt == FETCH_LOAD);
    assign bus.ir_we       = (r_state == FETCH) && w_cnt_last;
    assign bus.reg_we      = (r_state == WB) && r_ctrl.reg_we;
    assign bus.ram_we      = (r_state == MEM) && r_ctrl.store;
    assign bus.pc_we       = (r_state == WB);
    assign bus.stdin_pop   = (r_state == IO) && r_ctrl.stdin && bus.stdin_valid;
    assign bus.stdout_push = (r_state == IO) && r_ctrl.stdout && bus.stdout_ready;
    assign bus.busy        = (r_state != IDLE);

`ifdef SEQ_PERF_COUNTER_EN
    logic [31:0] r_cycle_count;
    logic [31:0] r_instret_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_count   <= '0;
            r_instret_count <= '0;
        end else begin
            if (r_state != IDLE) r_cycle_count <= r_cycle_count + 32'd1;
            if (r_state == WB)   r_instret_count <= r_instret_count + 32'd1;
        end
    end

    assign bus.cycle_count   = r_cycle_count;
    assign bus.instret_count = r_instret_count;
`else
    assign bus.cycle_count   = '0;
    assign bus.instret_count = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer with IMEM_LATENCY=1, DMEM_LATENCY=2.
module tb_core_sequencer;
    import core_pkg::*;

    localparam logic [6:0] S_IMEM = 7'b1000000;
    localparam logic [6:0] S_IR   = 7'b0100000;
    localparam logic [6:0] S_REG  = 7'b0010000;
    localparam logic [6:0] S_RAM  = 7'b0001000;
    localparam logic [6:0] S_PC   = 7'b0000100;
    localparam logic [6:0] S_POP  = 7'b0000010;
    localparam logic [6:0] S_PUSH = 7'b0000001;

    typedef struct {
        int         cyc;
        logic [6:0] s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tb_cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   base;
    exp_t sb[$];

    core_sequencer_if bus ();

    core_sequencer #(.IMEM_LATENCY(1), .DMEM_LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    function automatic logic [6:0] strobes();
        return {bus.imem_req, bus.ir_we, bus.reg_we, bus.ram_we, bus.pc_we,
                bus.stdin_pop, bus.stdout_push};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, tb_cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_dec(input logic rwe, input logic mwe, input logic [1:0] wsrc,
                           input logic din, input logic dout);
        bus.dec_reg_we    = rwe;
        bus.dec_ram_we    = mwe;
        bus.dec_wsrc      = wsrc;
        bus.dec_stdin_en  = din;
        bus.dec_stdout_en = dout;
    endtask

    // Expected event at instruction-relative cycle k (c0 = first FETCH cycle).
    task automatic push_ev(input int k, input logic [6:0] s);
        exp_t e;
        e.cyc = base + 1 + k;
        e.s   = s;
        sb.push_back(e);
    endtask

    // Monitor samples 1 ns before each rising edge.
    always begin
        logic [6:0] w;
        exp_t       e;
        @(negedge clk);
        #4;
        w = strobes();
        if (!rst && w != 7'd0) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: got %b at cycle %0d, expected none", w, tb_cyc);
            end else begin
                e = sb.pop_front();
                if (e.cyc != tb_cyc || e.s != w) begin
                    bad++;
                    $display("FAIL strobe_event: got %b at cycle %0d, expected %b at cycle %0d",
                             w, tb_cyc, e.s, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.run          = 1'b0;
        bus.stdin_valid  = 1'b0;
        bus.stdout_ready = 1'b0;
        set_dec(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick(3);
        check("reset_strobes", {25'd0, strobes()}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        tick(2);
        check("idle_busy", {31'd0, bus.busy}, 32'd0);

        // Two back-to-back ADDs: WB at c3, next fetch at c4.
        set_dec(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        base = tb_cyc;
        bus.run = 1'b1;
        push_ev(0, S_IMEM | S_IR);
        push_ev(3, S_REG | S_PC);
        push_ev(4, S_IMEM | S_IR);
        push_ev(7, S_REG | S_PC);
        tick(1);
        check("add_busy_fetch", {31'd0, bus.busy}, 32'd1);
        tick(4);
        bus.run = 1'b0;
        tick(4);
        check("add_parked", {31'd0, bus.busy}, 32'd0);
        tick(2);

        // Load, DMEM_LATENCY=2: MEM c3..c4, WB c5.
        set_dec(1'b1, 1'b0, REG_WRITE_DATA_SRC_RAM, 1'b0, 1'b0);
        base = tb_cyc;
        bus.run = 1'b1;
        push_ev(0, S_IMEM | S_IR);
        push_ev(5, S_REG | S_PC);
        tick(1);
        bus.run = 1'b0;
        tick(4);
        check("load_busy_mem", {31'd0, bus.busy}, 32'd1);
        tick(2);
        check("load_parked", {31'd0, bus.busy}, 32'd0);
        tick(2);

        // Store with dec_reg_we=1: ram_we c3, pc_we c4, reg_we masked.
        set_dec(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
        base = tb_cyc;
        bus.run = 1'b1;
        push_ev(0, S_IMEM | S_IR);
        push_ev(3, S_RAM);
        push_ev(4, S_REG & 7'd0 | S_PC);
        tick(1);
        bus.run = 1'b0;
        tick(5);
        check("store_parked", {31'd0, bus.busy}, 32'd0);
        tick(2);

        // stdin stalled 10 cycles in IO (c3..c12), pop at c13, WB c14.
        set_dec(1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
        base = tb_cyc;
        bus.run = 1'b1;
        push_ev(0, S_IMEM | S_IR);
        push_ev(13, S_POP);
        push_ev(14, S_REG | S_PC);
        tick(1);
        bus.run = 1'b0;
        tick(12);
        check("stdin_hold_busy", {31'd0, bus.busy}, 32'd1);
        tick(1);
        bus.stdin_valid = 1'b1;
        tick(1);
        bus.stdin_valid = 1'b0;
        tick(3);

        // stdout ready at c5: push c5, WB c6 without reg_we.
        set_dec(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        base = tb_cyc;
        bus.run = 1'b1;
        push_ev(0, S_IMEM | S_IR);
        push_ev(5, S_PUSH);
        push_ev(6, S_PC);
        tick(1);
        bus.run = 1'b0;
        tick(5);
        bus.stdout_ready = 1'b1;
        tick(1);
        bus.stdout_ready = 1'b0;
        tick(3);

        // stdin and stdout both requested, both ready: stdin wins, no push.
        set_dec(1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
        bus.stdin_valid  = 1'b1;
        bus.stdout_ready = 1'b1;
        base = tb_cyc;
        bus.run = 1'b1;
        push_ev(0, S_IMEM | S_IR);
        push_ev(3, S_POP);
        push_ev(4, S_PC);
        tick(1);
        bus.run = 1'b0;
        tick(5);
        bus.stdin_valid  = 1'b0;
        bus.stdout_ready = 1'b0;
        tick(2);

        // run dropped in EXEC: WB at c3, then parked with no fetch.
        set_dec(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        base = tb_cyc;
        bus.run = 1'b1;
        push_ev(0, S_IMEM | S_IR);
        push_ev(3, S_REG | S_PC);
        tick(3);
        bus.run = 1'b0;
        tick(2);
        check("run_drop_parked", {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("no_fetch_when_parked", {30'd0, bus.imem_req, bus.busy}, 32'd0);
        end

`ifdef SEQ_PERF_COUNTER_EN
        check("instret_count", bus.instret_count, 32'd8);
`else
        check("instret_tied", bus.instret_count, 32'd0);
        check("cycle_tied", bus.cycle_count, 32'd0);
`endif

        // Asynchronous reset in the MEM cycle of a store, between clock edges.
        set_dec(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        base = tb_cyc;
        bus.run = 1'b1;
        push_ev(0, S_IMEM | S_IR);
        tick(1);
        bus.run = 1'b0;
        tick(3);
        #1;
        check("mem_ram_we_before_rst", {31'd0, bus.ram_we}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_strobes", {25'd0, strobes()}, 32'd0);
        check("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("async_rst_cycle_count", bus.cycle_count, 32'd0);
        check("async_rst_instret", bus.instret_count, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(5);
        check("post_rst_idle", {31'd0, bus.busy}, 32'd0);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
